mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that answers the pipelined core's data-memory port. Address decode outside the block drives `cs` for this block's range; RAM serves the remainder.
- The CPU writes bytes into a TX FIFO.
- The block serialises them 8N1 on `tx` at a programmable bit period.
- A status register is readable for software polling.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2
DEFAULT_DIV, 16'd433, BAUDDIV reset value; bit period = DIV+1 clocks
ADDR_W, 10, width of daddr

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
cs  in  1  block selected for the current access
daddr  in  ADDR_W  byte address; daddr[3:2] selects the register
ddata_w  in  32  write data
d_w  in  1  write strobe
d_r  in  1  read strobe
ddata_r  out  32  read data
tx  out  1  serial line; idle high
irq_empty  out  1  high while FIFO empty and FSM idle

Behaviour:
Register map (daddr[3:2]):
- 0 TXDATA: a write enqueues ddata_w[7:0]; a read returns 0.
- 1 STATUS:
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
  - bits[7:4] FIFO count, saturated to 15.
  - Writing 1 to bit3 clears overflow; other bits are read-only.
- 2 BAUDDIV: bits[15:0] RW; upper bits read 0.
- 3 CTRL: bit0 enable, RW; upper bits read 0.

Bus rules:
- Read is combinational, so ddata_r is valid in the same cycle as cs&d_r. This matches the RAM timing the core expects.
- ddata_r = 0 when !(cs&d_r).
- A write takes effect at the rising edge where cs&d_w is high.
- d_w and d_r together: the read returns pre-edge contents and the write applies at the edge.

Reset (RST high at an edge):
- FIFO emptied, FSM to IDLE, tx=1.
- BAUDDIV=DEFAULT_DIV, enable=1, overflow=0, ddata_r=0.
- An in-flight frame is abandoned and tx is high from the next edge.

FIFO:
- A write to TXDATA is accepted if not full, or if a dequeue occurs in the same cycle (count unchanged).
- Otherwise the byte is dropped and overflow is set.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

FSM (state register plus bit counter 0..7, baud counter 0..DIV):
- IDLE: tx=1. If enable and FIFO non-empty: dequeue into the shift register, load baud counter, go to START.
- START: tx=0 for DIV+1 cycles, then DATA with bit index 0.
- DATA: tx=shift[0], LSB first. Each bit lasts DIV+1 cycles, then shift right. After bit 7, go to STOP.
- STOP: tx=1 for DIV+1 cycles, then IDLE.
  - If enable and FIFO non-empty at that point, go directly to START (back-to-back, no idle gap).

Timing and control:
- Byte written at edge k into an empty FIFO in IDLE: tx falls at edge k+1.
- Frame length is 10*(DIV+1) cycles.
- BAUDDIV written mid-frame is used from the next baud-counter reload, i.e. the next bit.
- DIV=0 gives 1 cycle per bit.
- enable cleared mid-frame: the current frame completes, then no further dequeue. FIFO contents are retained.

Outputs:
- tx is registered; no combinational path from the bus to tx.
- irq_empty = empty & (state==IDLE), registered.

Decomposition:
- Package uart_tx_pkg:
  - state enum tx_state_t {IDLE, START, DATA, STOP}.
  - Register offset constants REG_TXDATA=2'd0, REG_STATUS=2'd1, REG_BAUDDIV=2'd2, REG_CTRL=2'd3.
  - STATUS bit-index constants.
- One sub-module: sync_fifo (params WIDTH=8, DEPTH)
  - Ports: CLK, RST, push, pop, din, dout (head, valid when !empty), full, empty, count.
  - Push-when-full-with-pop is allowed.

Test Plan:
1. Reset then read STATUS -> 0x00000002 (empty). BAUDDIV reads 433, CTRL reads 1, tx=1, irq_empty=1.
2. BAUDDIV=3, write TXDATA 0xA5 at edge k -> tx falls at k+1. Sampled bits over 40 cycles are 0,1,0,1,0,0,1,0,1,1 (start, LSB first 0xA5, stop). busy=1 during the frame. irq_empty returns to 1 after the frame.
3. BAUDDIV=0, enable=0, write 9 bytes 0x01..0x09 (DEPTH 8) -> count=8, full=1, overflow=1. Writing 0x8 to STATUS clears overflow. Setting enable=1 transmits 0x01..0x08 back-to-back with no idle cycles between stop and the next start.
4. FIFO full while transmitting with DIV=0: write TXDATA in the exact cycle of a dequeue -> accepted, count stays 8, no overflow.
5. Mid-frame (in DATA, bit 3) assert RST for one cycle -> tx=1 at the next edge, STATUS=0x2, and no resumption of the old byte.
6. BAUDDIV change 3->1 during DATA bit 2 -> bit 2 keeps 4 cycles, bits 3..7 and stop are 2 cycles each. Also d_r with cs=0 -> ddata_r=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM state encoding, register offsets and STATUS bit positions.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 7;

  // The count field is only four bits wide; deeper FIFOs report 15.
  function automatic logic [3:0] sat_nibble(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised; a push while
// full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO and a
// serialiser FSM with a programmable bit period of DIV+1 clocks.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int          ADDR_W      = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cs,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       ddata_w,
  input  logic              d_w,
  input  logic              d_r,
  output logic [31:0]       ddata_r,
  output logic              tx,
  output logic              irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   state_q;
  logic [2:0]  bit_q;
  logic [15:0] baud_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        irq_q;
  logic [15:0] div_q;
  logic        en_q;
  logic        ovf_q;

  logic [1:0]    sel;
  logic          wr_en;
  logic          rd_en;
  logic          push;
  logic          deq;
  logic          start_ok;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel      = daddr[3:2];
  assign wr_en    = cs & d_w;
  assign rd_en    = cs & d_r & ~RST;
  assign push     = wr_en & (sel == REG_TXDATA);
  assign start_ok = en_q & ~fifo_empty;
  // Dequeue either from IDLE or in the final STOP cycle for back-to-back frames.
  assign deq      = start_ok & ((state_q == IDLE) ||
                                ((state_q == STOP) && (baud_q == '0)));

  assign unused_bits = ^{daddr[ADDR_W-1:4], daddr[1:0], ddata_w[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (deq),
    .din   (ddata_w[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= DEFAULT_DIV;
      en_q  <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en && (sel == REG_BAUDDIV)) div_q <= ddata_w[15:0];
      if (wr_en && (sel == REG_CTRL))    en_q  <= ddata_w[0];
      if (push && fifo_full && !deq)
        ovf_q <= 1'b1;
      else if (wr_en && (sel == REG_STATUS) && ddata_w[STAT_OVF])
        ovf_q <= 1'b0;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    status = '0;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY]  = (state_q != IDLE);
    status[STAT_OVF]   = ovf_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = sat_nibble(32'(fifo_count));
  end

  always_comb begin
    ddata_r = '0;
    if (rd_en) begin
      unique case (sel)
        REG_STATUS:  ddata_r = status;
        REG_BAUDDIV: ddata_r = {16'd0, div_q};
        REG_CTRL:    ddata_r = {31'd0, en_q};
        default:     ddata_r = '0;
      endcase
    end
  end

  // tx is computed alongside the next state so it is a plain register output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= '0;
      baud_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      irq_q <= fifo_empty & (state_q == IDLE);
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (start_ok) begin
            shift_q <= fifo_dout;
            baud_q  <= div_q;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == '0) begin
            bit_q   <= '0;
            baud_q  <= div_q;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            baud_q <= div_q;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        STOP: begin
          if (baud_q == '0) begin
            if (start_ok) begin
              shift_q <= fifo_dout;
              baud_q  <= div_q;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow and simultaneous push/pop, mid-frame reset and live BAUDDIV change.
module tb_mmio_uart_tx;

  localparam logic [9:0] A_TXDATA  = 10'h000;
  localparam logic [9:0] A_STATUS  = 10'h004;
  localparam logic [9:0] A_BAUDDIV = 10'h008;
  localparam logic [9:0] A_CTRL    = 10'h00C;

  logic        CLK;
  logic        RST;
  logic        cs;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_w;
  logic        d_r;
  logic [31:0] ddata_r;
  logic        tx;
  logic        irq_empty;

  int total;
  int bad;

  mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd433), .ADDR_W(10)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cs        (cs),
    .daddr     (daddr),
    .ddata_w   (ddata_w),
    .d_w       (d_w),
    .d_r       (d_r),
    .ddata_r   (ddata_r),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [9:0] addr, input logic [31:0] data);
    daddr   = addr;
    ddata_w = data;
    cs      = 1'b1;
    d_w     = 1'b1;
    @(posedge CLK);
    #1;
    cs  = 1'b0;
    d_w = 1'b0;
  endtask

  // Combinational read that does not cross a clock edge.
  task automatic peek(input logic [9:0] addr, output logic [31:0] data);
    daddr = addr;
    cs    = 1'b1;
    d_r   = 1'b1;
    #1;
    data = ddata_r;
    cs   = 1'b0;
    d_r  = 1'b0;
  endtask

  // Expected 8N1 line level for frame position idx (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return v[idx-1];
  endfunction

  initial begin
    logic [31:0] rd;
    logic [0:9]  f_a5;
    logic [0:27] exp6;
    logic        saw_low;

    total   = 0;
    bad     = 0;
    RST     = 1'b1;
    cs      = 1'b0;
    d_w     = 1'b0;
    d_r     = 1'b0;
    daddr   = '0;
    ddata_w = '0;
    f_a5    = 10'b0101001011;
    exp6    = 28'b0000_0000_0000_1111_00_11_11_00_00_11;

    repeat (2) tick();
    RST = 1'b0;

    // 1: reset state
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq_empty}, 32'd1);
    check("rst_rdata_idle", ddata_r, 32'd0);
    peek(A_STATUS, rd);  check("rst_status", rd, 32'h2);
    peek(A_BAUDDIV, rd); check("rst_bauddiv", rd, 32'd433);
    peek(A_CTRL, rd);    check("rst_ctrl", rd, 32'd1);
    peek(A_TXDATA, rd);  check("txdata_reads_zero", rd, 32'd0);

    // 2: single frame 0xA5 at DIV=3
    bus_write(A_BAUDDIV, 32'd3);
    bus_write(A_TXDATA, 32'hA5);
    check("a5_pre_start", {31'd0, tx}, 32'd1);
    for (int c = 0; c < 40; c++) begin
      tick();
      check($sformatf("a5_cyc%0d", c), {31'd0, tx}, {31'd0, f_a5[c/4]});
      if (c == 20) begin
        peek(A_STATUS, rd);
        check("a5_status_busy", rd, 32'h6);
        check("a5_irq_low", {31'd0, irq_empty}, 32'd0);
      end
    end
    repeat (2) tick();
    check("a5_irq_back", {31'd0, irq_empty}, 32'd1);
    peek(A_STATUS, rd); check("a5_status_after", rd, 32'h2);

    // 3: overflow with enable off, then back-to-back drain at DIV=0
    bus_write(A_BAUDDIV, 32'd0);
    bus_write(A_CTRL, 32'd0);
    for (int i = 1; i <= 9; i++) bus_write(A_TXDATA, 32'(i));
    peek(A_STATUS, rd); check("ovf_status", rd, 32'h89);
    check("ovf_tx_idle", {31'd0, tx}, 32'd1);
    bus_write(A_STATUS, 32'h8);
    peek(A_STATUS, rd); check("ovf_cleared", rd, 32'h81);
    bus_write(A_CTRL, 32'd1);
    for (int c = 0; c < 80; c++) begin
      tick();
      check($sformatf("b2b_cyc%0d", c), {31'd0, tx},
            {31'd0, frame_bit(8'(c/10 + 1), c % 10)});
    end
    repeat (2) tick();
    peek(A_STATUS, rd); check("b2b_status_after", rd, 32'h2);

    // 4: push into a full FIFO in the same cycle as a dequeue
    bus_write(A_CTRL, 32'd0);
    for (int i = 0; i < 8; i++) bus_write(A_TXDATA, 32'(8'h11 + i));
    peek(A_STATUS, rd); check("full_status", rd, 32'h81);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TXDATA, 32'h19);
    peek(A_STATUS, rd); check("pushpop_status", rd, 32'h85);
    for (int c = 0; c < 90; c++) begin
      if (c > 0) tick();
      check($sformatf("pushpop_cyc%0d", c), {31'd0, tx},
            {31'd0, frame_bit(8'(8'h11 + c/10), c % 10)});
    end
    repeat (2) tick();
    peek(A_STATUS, rd); check("pushpop_after", rd, 32'h2);

    // 5: reset in the middle of DATA bit 3 (0x52 has bit3 = 0)
    bus_write(A_BAUDDIV, 32'd3);
    bus_write(A_TXDATA, 32'h52);
    repeat (18) tick();
    check("rst_mid_bit3", {31'd0, tx}, 32'd0);
    RST = 1'b1;
    tick();
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_irq", {31'd0, irq_empty}, 32'd1);
    RST = 1'b0;
    peek(A_STATUS, rd);  check("rst_mid_status", rd, 32'h2);
    peek(A_BAUDDIV, rd); check("rst_mid_bauddiv", rd, 32'd433);
    peek(A_CTRL, rd);    check("rst_mid_ctrl", rd, 32'd1);
    saw_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("rst_mid_no_resume", {31'd0, saw_low}, 32'd0);

    // 6: BAUDDIV 3 -> 1 during bit 2 of 0x34
    bus_write(A_BAUDDIV, 32'd3);
    bus_write(A_TXDATA, 32'h34);
    for (int c = 1; c <= 28; c++) begin
      if (c == 14) bus_write(A_BAUDDIV, 32'd1);
      else tick();
      check($sformatf("div_chg_cyc%0d", c), {31'd0, tx}, {31'd0, exp6[c-1]});
      if (c == 28) begin
        peek(A_STATUS, rd);
        check("div_chg_busy_last", rd, 32'h6);
      end
    end
    tick();
    peek(A_STATUS, rd); check("div_chg_idle", rd, 32'h2);

    // read with cs low, and simultaneous read/write of BAUDDIV
    daddr = A_CTRL;
    d_r   = 1'b1;
    #1;
    check("rd_without_cs", ddata_r, 32'd0);
    d_r     = 1'b0;
    daddr   = A_BAUDDIV;
    ddata_w = 32'd7;
    cs      = 1'b1;
    d_r     = 1'b1;
    d_w     = 1'b1;
    #1;
    check("rw_same_cycle_old", ddata_r, 32'd1);
    tick();
    cs  = 1'b0;
    d_r = 1'b0;
    d_w = 1'b0;
    peek(A_BAUDDIV, rd); check("rw_same_cycle_new", rd, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
